servo_frame_scheduler: RTL and testbench

// - Owns the 20-bit PWM frame for NUM_CH servo channels and drives the A/B operands of the per-channel

---
 rtl/servo_frame_scheduler_pkg.sv | 31 +++
 rtl/servo_frame_scheduler_if.sv | 27 ++
 rtl/servo_frame_scheduler_slew.sv | 28 ++
 rtl/servo_frame_scheduler.sv | 159 +++++++++++++++
 tb/tb_servo_frame_scheduler.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/servo_frame_scheduler_pkg.sv
// Shared widths, FSM encoding, command payload and the position clamp helper.
package servo_frame_scheduler_pkg;

  localparam int unsigned POS_W    = 20;
  localparam int unsigned CH_IDX_W = 3;

  typedef logic [POS_W-1:0] pos_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_UPDATE = 1'b1
  } state_t;

  typedef struct packed {
    logic [CH_IDX_W-1:0] ch;
    pos_t                pos;
  } cmd_t;

  // Saturate a requested pulse width into the legal [lo, hi] window.
  function automatic pos_t clamp_pos(input pos_t p, input pos_t lo, input pos_t hi);
    pos_t r;
    r = p;
    if (p < lo) begin
      r = lo;
    end else if (p > hi) begin
      r = hi;
    end
    return r;
  endfunction

endpackage

// File: rtl/servo_frame_scheduler_if.sv
// Command port and comparator-operand bus of the servo frame scheduler.
interface servo_frame_scheduler_if #(
  parameter int unsigned NUM_CH = 4
) ();
  import servo_frame_scheduler_pkg::*;

  logic [NUM_CH-1:0]       en_mask;
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [CH_IDX_W-1:0]     cmd_ch;
  pos_t                    cmd_pos;
  pos_t                    frame_cnt;
  logic [POS_W*NUM_CH-1:0] thresh;
  logic                    frame_start;
  logic [NUM_CH-1:0]       settled;

  modport master (
    output en_mask, cmd_valid, cmd_ch, cmd_pos,
    input  cmd_ready, frame_cnt, thresh, frame_start, settled
  );

  modport slave (
    input  en_mask, cmd_valid, cmd_ch, cmd_pos,
    output cmd_ready, frame_cnt, thresh, frame_start, settled
  );

endinterface

// File: rtl/servo_frame_scheduler_slew.sv
// Moves cur_pos toward target by at most STEP; purely combinational.
module servo_frame_scheduler_slew
  import servo_frame_scheduler_pkg::*;
#(
  parameter int unsigned STEP = 500
) (
  input  pos_t target,
  input  pos_t cur_pos,
  output pos_t next_pos_c
);

  localparam logic signed [POS_W:0] STEP_S = (POS_W+1)'(STEP);
  localparam pos_t                  STEP_P = POS_W'(STEP);

  logic signed [POS_W:0] diff;

  // Signed distance to target, then step-limited move (no overflow: max+STEP fits).
  always_comb begin
    diff       = $signed({1'b0, target}) - $signed({1'b0, cur_pos});
    next_pos_c = target;
    if (diff > STEP_S) begin
      next_pos_c = cur_pos + STEP_P;
    end else if (diff < -STEP_S) begin
      next_pos_c = cur_pos - STEP_P;
    end
  end

endmodule

// File: rtl/servo_frame_scheduler.sv
// PWM frame counter, per-channel slew-limited thresholds updated only at frame start.
module servo_frame_scheduler
  import servo_frame_scheduler_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned PERIOD    = 1_000_000,
  parameter int unsigned PULSE_MIN = 50_000,
  parameter int unsigned PULSE_MAX = 100_000,
  parameter int unsigned STEP      = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  servo_frame_scheduler_if.slave  bus
);

  localparam pos_t                CENTER   = POS_W'((PULSE_MIN + PULSE_MAX) / 2);
  localparam pos_t                P_MIN    = POS_W'(PULSE_MIN);
  localparam pos_t                P_MAX    = POS_W'(PULSE_MAX);
  localparam pos_t                LAST_CNT = POS_W'(PERIOD - 1);
  localparam logic [CH_IDX_W-1:0] LAST_IDX = CH_IDX_W'(NUM_CH - 1);

  // Parameter sanity: thresholds must only move while every comparator output is high.
  if (NUM_CH < 1 || NUM_CH > 8) begin : g_chk_ch
    $error("servo_frame_scheduler: NUM_CH must be 1..8");
  end
  if (PERIOD > (1 << POS_W) || PULSE_MAX >= PERIOD) begin : g_chk_period
    $error("servo_frame_scheduler: need PULSE_MAX < PERIOD <= 2**20");
  end
  if (PULSE_MIN <= NUM_CH + 1 || PULSE_MIN > PULSE_MAX || STEP < 1) begin : g_chk_pulse
    $error("servo_frame_scheduler: illegal PULSE_MIN/PULSE_MAX/STEP");
  end

  state_t                  state, state_nxt;
  logic [CH_IDX_W-1:0]     idx, idx_nxt;
  logic                    cmd_ready_q, cmd_ready_nxt;
  logic                    upd_c, wrap_c, accept_c;
  pos_t                    frame_cnt_q;
  logic                    frame_start_q;
  pos_t                    target_q [NUM_CH];
  pos_t                    cur_q    [NUM_CH];
  pos_t                    thresh_q [NUM_CH];
  pos_t                    sel_target_c, sel_cur_c, next_pos_c, cmd_pos_clamped_c;
  logic                    sel_en_c;
  cmd_t                    cmd_c;
  logic [NUM_CH-1:0]       settled_c;
  logic [POS_W*NUM_CH-1:0] thresh_flat_c;

  assign wrap_c            = (frame_cnt_q == LAST_CNT);
  assign cmd_c             = '{ch: bus.cmd_ch, pos: bus.cmd_pos};
  assign cmd_pos_clamped_c = clamp_pos(cmd_c.pos, P_MIN, P_MAX);
  assign accept_c          = bus.cmd_valid && cmd_ready_q;

  // FSM state, visit index and registered ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      idx         <= '0;
      cmd_ready_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      cmd_ready_q <= cmd_ready_nxt;
    end
  end

  // Next state: UPDATE on the wrap edge, then one channel per clock.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      ST_RUN: begin
        if (wrap_c) begin
          state_nxt = ST_UPDATE;
          idx_nxt   = '0;
        end
      end
      ST_UPDATE: begin
        if (idx == LAST_IDX) begin
          state_nxt = ST_RUN;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + CH_IDX_W'(1);
        end
      end
      default: begin
        state_nxt = ST_RUN;
        idx_nxt   = '0;
      end
    endcase
  end

  // FSM outputs: ready tracks the upcoming state so it is registered yet exact.
  always_comb begin
    cmd_ready_nxt = (state_nxt == ST_RUN);
    upd_c         = (state == ST_UPDATE);
  end

  // Select the channel being visited for the shared slew unit.
  always_comb begin
    sel_target_c = target_q[0];
    sel_cur_c    = cur_q[0];
    sel_en_c     = bus.en_mask[0];
    for (int i = 0; i < NUM_CH; i++) begin
      if (idx == CH_IDX_W'(i)) begin
        sel_target_c = target_q[i];
        sel_cur_c    = cur_q[i];
        sel_en_c     = bus.en_mask[i];
      end
    end
  end

  servo_frame_scheduler_slew #(.STEP(STEP)) u_slew (
    .target     (sel_target_c),
    .cur_pos    (sel_cur_c),
    .next_pos_c (next_pos_c)
  );

  // Frame counter, target writes and per-visit position/threshold updates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt_q   <= '0;
      frame_start_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        target_q[i] <= CENTER;
        cur_q[i]    <= CENTER;
        thresh_q[i] <= '0;
      end
    end else begin
      frame_cnt_q   <= wrap_c ? '0 : frame_cnt_q + POS_W'(1);
      frame_start_q <= wrap_c;
      for (int i = 0; i < NUM_CH; i++) begin
        if (accept_c && cmd_c.ch == CH_IDX_W'(i)) begin
          target_q[i] <= cmd_pos_clamped_c;
        end
        if (upd_c && idx == CH_IDX_W'(i)) begin
          cur_q[i]    <= next_pos_c;
          thresh_q[i] <= sel_en_c ? next_pos_c : '0;
        end
      end
    end
  end

  // Flatten thresholds and derive settled flags from the registers.
  always_comb begin
    thresh_flat_c = '0;
    settled_c     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      thresh_flat_c[i*POS_W +: POS_W] = thresh_q[i];
      settled_c[i]                    = (cur_q[i] == target_q[i]);
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.frame_cnt   = frame_cnt_q;
  assign bus.frame_start = frame_start_q;
  assign bus.thresh      = thresh_flat_c;
  assign bus.settled     = settled_c;

endmodule

// File: tb/tb_servo_frame_scheduler.sv
// Randomised bench for servo_frame_scheduler against a frame-level reference model.
module tb_servo_frame_scheduler;

  localparam int NUM_CH = 4;
  localparam int PERIOD = 1000;
  localparam int PMIN   = 50;
  localparam int PMAX   = 100;
  localparam int STEP   = 10;
  localparam int CENTER = (PMIN + PMAX) / 2;

  logic clk;
  logic rst_n;
  bit   chk_on;
  int   n_checks;
  int   n_fail;

  servo_frame_scheduler_if #(.NUM_CH(NUM_CH)) bus ();

  servo_frame_scheduler #(
    .NUM_CH(NUM_CH), .PERIOD(PERIOD), .PULSE_MIN(PMIN), .PULSE_MAX(PMAX), .STEP(STEP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: position within the frame and per-channel positions.
  int m_cnt;
  bit m_wrapped;
  bit m_ready;
  bit m_fs;
  int m_tgt [NUM_CH];
  int m_cur [NUM_CH];
  int m_thr [NUM_CH];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp(input int p);
    if (p < PMIN) return PMIN;
    if (p > PMAX) return PMAX;
    return p;
  endfunction

  function automatic logic [19:0] thr_of(input int ch);
    return bus.thresh[ch*20 +: 20];
  endfunction

  // Model: the first NUM_CH cycles of every frame after a wrap revisit one channel each.
  always @(posedge clk) begin
    int i, d;
    if (!rst_n) begin
      m_cnt = 0; m_wrapped = 0; m_ready = 0; m_fs = 0;
      for (int c = 0; c < NUM_CH; c++) begin
        m_tgt[c] = CENTER; m_cur[c] = CENTER; m_thr[c] = 0;
      end
    end else begin
      if (m_wrapped && m_cnt < NUM_CH) begin
        i = m_cnt;
        d = m_tgt[i] - m_cur[i];
        if (d > STEP)       m_cur[i] = m_cur[i] + STEP;
        else if (d < -STEP) m_cur[i] = m_cur[i] - STEP;
        else                m_cur[i] = m_tgt[i];
        m_thr[i] = bus.en_mask[i] ? m_cur[i] : 0;
      end else if (bus.cmd_valid && m_ready && int'(bus.cmd_ch) < NUM_CH) begin
        m_tgt[bus.cmd_ch] = clamp(int'(bus.cmd_pos));
      end
      m_cnt = (m_cnt == PERIOD - 1) ? 0 : m_cnt + 1;
      if (m_cnt == 0) m_wrapped = 1;
      m_fs    = (m_cnt == 0);
      m_ready = !(m_wrapped && m_cnt < NUM_CH);
    end
  end

  // Compare every output against the model away from the active edge.
  always @(negedge clk) begin
    logic [NUM_CH-1:0] es;
    if (chk_on) begin
      check_eq("frame_cnt", 32'(bus.frame_cnt), m_cnt);
      check_eq("frame_start", 32'(bus.frame_start), 32'(m_fs));
      check_eq("cmd_ready", 32'(bus.cmd_ready), 32'(m_ready));
      for (int c = 0; c < NUM_CH; c++) begin
        check_eq($sformatf("thresh%0d", c), 32'(thr_of(c)), m_thr[c]);
        es[c] = (m_cur[c] == m_tgt[c]);
      end
      check_eq("settled", 32'(bus.settled), 32'(es));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cnt(input int v);
    int n;
    n = 0;
    while (m_cnt != v && n < 2 * PERIOD) begin
      tick();
      n++;
    end
    if (m_cnt != v) check_eq("wait_cnt_timeout", m_cnt, v);
  endtask

  task automatic next_frame_at(input int v);
    tick();
    wait_cnt(0);
    wait_cnt(v);
  endtask

  task automatic send(input int ch, input int pos, output int waits);
    logic r;
    bus.cmd_valid = 1'b1;
    bus.cmd_ch    = 3'(ch);
    bus.cmd_pos   = 20'(pos);
    waits = 0;
    r = 1'b0;
    while (!r && waits < 3 * PERIOD) begin
      @(negedge clk);
      r = bus.cmd_ready;
      tick();
      waits++;
    end
    if (!r) check_eq("send_timeout", 32'(r), 32'd1);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_frame_cnt"}, 32'(bus.frame_cnt), 0);
    check_eq({pfx, "_cmd_ready"}, 32'(bus.cmd_ready), 0);
    check_eq({pfx, "_frame_start"}, 32'(bus.frame_start), 0);
    check_eq({pfx, "_settled"}, 32'(bus.settled), 32'hF);
    for (int c = 0; c < NUM_CH; c++)
      check_eq($sformatf("%s_thresh%0d", pfx, c), 32'(thr_of(c)), 0);
  endtask

  initial begin
    int w;
    n_checks = 0; n_fail = 0; chk_on = 0;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_ch = '0; bus.cmd_pos = '0; bus.en_mask = '1;

    // Reset held for three clocks.
    tick();
    chk_on = 1;
    tick(); tick();
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // Frame 0: slew request, clamp-low request and an out-of-range channel.
    send(1, 100, w);
    send(2, 20, w);
    send(6, 90, w);

    // Frames 1..3: stepped approach and settling point.
    next_frame_at(4);
    check_eq("f1_thr0", 32'(thr_of(0)), 75);
    check_eq("f1_thr1", 32'(thr_of(1)), 85);
    check_eq("f1_thr2", 32'(thr_of(2)), 65);
    check_eq("f1_thr3", 32'(thr_of(3)), 75);
    check_eq("f1_settled", 32'(bus.settled), 32'b1001);
    next_frame_at(4);
    check_eq("f2_thr1", 32'(thr_of(1)), 95);
    check_eq("f2_thr2", 32'(thr_of(2)), 55);
    next_frame_at(1);
    check_eq("f3_thr1_before", 32'(thr_of(1)), 95);
    check_eq("f3_settled1_before", 32'(bus.settled[1]), 0);
    wait_cnt(2);
    check_eq("f3_thr1", 32'(thr_of(1)), 100);
    check_eq("f3_settled1", 32'(bus.settled[1]), 1);
    wait_cnt(3);
    check_eq("f3_thr2", 32'(thr_of(2)), 50);

    // Frame 4: command held across UPDATE completes on the first RUN cycle.
    next_frame_at(1);
    send(3, 60, w);
    check_eq("stall_wait", w, NUM_CH);
    wait_cnt(500);
    bus.en_mask[3] = 1'b0;

    // Frame 5: disabled channel drops to 0 only at its visit.
    next_frame_at(3);
    check_eq("dis_thr3_before", 32'(thr_of(3)), 75);
    wait_cnt(4);
    check_eq("dis_thr3_after", 32'(thr_of(3)), 0);
    wait_cnt(500);
    bus.en_mask[3] = 1'b1;
    send(0, 100, w);

    // Frame 6: re-enabled channel shows the position that kept slewing.
    next_frame_at(4);
    check_eq("reen_thr3", 32'(thr_of(3)), 60);
    check_eq("reen_thr0", 32'(thr_of(0)), 85);

    // Frame 7: reset in the middle of UPDATE.
    next_frame_at(2);
    rst_n = 1'b0;
    tick(); tick(); tick();
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    next_frame_at(4);
    for (int c = 0; c < NUM_CH; c++)
      check_eq($sformatf("postrst_thr%0d", c), 32'(thr_of(c)), CENTER);
    check_eq("postrst_settled", 32'(bus.settled), 32'hF);

    // Random commands, channels, positions and enable masks.
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(1, 300)) tick();
      if ($urandom_range(0, 3) == 0) bus.en_mask = 4'($urandom);
      if ($urandom_range(0, 1) == 1)
        send($urandom_range(0, 7), $urandom_range(30, 120), w);
      else
        send($urandom_range(0, 7), int'(20'($urandom)), w);
    end
    bus.en_mask = '1;
    next_frame_at(10);
    next_frame_at(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
